// File: rtl/ddr3_pkg.sv
// Shared DDR3 command-arbiter definitions: command type, PHY pin encodings,
// FSM state type and default timing constants.
package ddr3_pkg;

    localparam int unsigned DEF_T_RRD = 4;
    localparam int unsigned DEF_T_CCD = 4;
    localparam int unsigned DEF_T_RFC = 64;

    // Encodings 5..7 are undefined and are treated like NOP.
    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } ddr3_cmd_t;

    typedef enum logic {
        ST_ARB      = 1'b0,
        ST_RFC_WAIT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } ddr3_pins_t;

    localparam ddr3_pins_t PINS_NOP = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};
    localparam ddr3_pins_t PINS_ACT = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b1, we_n: 1'b1};
    localparam ddr3_pins_t PINS_RD  = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b0, we_n: 1'b1};
    localparam ddr3_pins_t PINS_WR  = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b0, we_n: 1'b0};
    localparam ddr3_pins_t PINS_PRE = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b1, we_n: 1'b0};
    localparam ddr3_pins_t PINS_REF = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b1};

    // Pin pattern for a bank command; anything not a real command drives NOP.
    function automatic ddr3_pins_t cmd_pins(input ddr3_cmd_t cmd);
        case (cmd)
            CMD_ACT: return PINS_ACT;
            CMD_RD:  return PINS_RD;
            CMD_WR:  return PINS_WR;
            CMD_PRE: return PINS_PRE;
            default: return PINS_NOP;
        endcase
    endfunction

    function automatic logic is_col_cmd(input ddr3_cmd_t cmd);
        return (cmd == CMD_RD) || (cmd == CMD_WR);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: first set req bit starting at ptr, wrapping.
// Ports: req (request vector), ptr (highest-priority index),
//        grant_onehot / grant_idx (winner), grant_any (some request won).
// N must be a power of two so the index wraps by natural overflow.
module rr_arbiter #(
    parameter  int unsigned N     = 8,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] idx;

    // Walk ptr, ptr+1, ... and latch the first requester found.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_any    = 1'b0;
        idx          = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ptr + IDX_W'(i);
            if (!grant_any && req[idx]) begin
                grant_any         = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_cmd_arb.sv
// DDR3 command arbiter: round-robin grant among per-bank requesters with
// tRRD/tCCD spacing, refresh priority and a tRFC blackout, driving
// registered PHY command pins one cycle after each grant.
// Ports: clk, rst_n (sync, active-low); bank_cmd_valid/type/addr in,
//        bank_cmd_ready (one-hot, same-cycle) out; next_prio_bank (pointer
//        used by the next arbitration); refresh_cmd_valid in,
//        refresh_cmd_ready out; ddr3_cs_n/ras_n/cas_n/we_n, ddr3_ba,
//        ddr3_addr registered PHY outputs.
module ddr3_cmd_arb
    import ddr3_pkg::*;
#(
    parameter  int unsigned NUM_BANKS = 8,
    parameter  int unsigned ADDR_W    = 14,
    parameter  int unsigned T_RRD     = DEF_T_RRD,
    parameter  int unsigned T_CCD     = DEF_T_CCD,
    parameter  int unsigned T_RFC     = DEF_T_RFC,
    localparam int unsigned BA_W      = $clog2(NUM_BANKS)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_BANKS-1:0]                bank_cmd_valid,
    input  ddr3_cmd_t [NUM_BANKS-1:0]           bank_cmd_type,
    input  logic [NUM_BANKS-1:0][ADDR_W-1:0]    bank_addr,
    output logic [NUM_BANKS-1:0]                bank_cmd_ready,
    output logic [BA_W-1:0]                     next_prio_bank,
    input  logic                                refresh_cmd_valid,
    output logic                                refresh_cmd_ready,
    output logic                                ddr3_cs_n,
    output logic                                ddr3_ras_n,
    output logic                                ddr3_cas_n,
    output logic                                ddr3_we_n,
    output logic [BA_W-1:0]                     ddr3_ba,
    output logic [ADDR_W-1:0]                   ddr3_addr
);

    localparam int unsigned RRD_W = $clog2(T_RRD + 1);
    localparam int unsigned CCD_W = $clog2(T_CCD + 1);
    localparam int unsigned RFC_W = $clog2(T_RFC + 1);

    arb_state_t         state_q, state_d;
    logic [RRD_W-1:0]   rrd_cnt_q;
    logic [CCD_W-1:0]   ccd_cnt_q;
    logic [RFC_W-1:0]   rfc_cnt_q;
    logic [BA_W-1:0]    prio_q;
    ddr3_pins_t         pins_q, pins_d;
    logic [BA_W-1:0]    ba_q, ba_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic [NUM_BANKS-1:0] eligible;
    logic [NUM_BANKS-1:0] arb_req;
    logic [NUM_BANKS-1:0] grant_onehot;
    logic [BA_W-1:0]      grant_idx;
    logic                 grant_any;
    logic                 arb_en;
    logic                 refresh_take;
    ddr3_cmd_t            grant_type;
    ddr3_pins_t           grant_pins;

    // Arbitration only runs out of reset in ARB; refresh pre-empts banks.
    assign arb_en       = rst_n && (state_q == ST_ARB);
    assign refresh_take = arb_en && refresh_cmd_valid;
    assign arb_req      = (arb_en && !refresh_cmd_valid) ? eligible : '0;
    assign grant_type   = bank_cmd_type[grant_idx];
    assign grant_pins   = cmd_pins(grant_type);

    // Spacing-blocked banks drop out of the search instead of stalling it.
    always_comb begin
        eligible = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            eligible[b] = bank_cmd_valid[b]
                && !((bank_cmd_type[b] == CMD_ACT) && (rrd_cnt_q != '0))
                && !(is_col_cmd(bank_cmd_type[b]) && (ccd_cnt_q != '0));
        end
    end

    rr_arbiter #(.N(NUM_BANKS)) u_rr_arbiter (
        .req          (arb_req),
        .ptr          (prio_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_any    (grant_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:      if (refresh_cmd_valid) state_d = ST_RFC_WAIT;
            ST_RFC_WAIT: if (rfc_cnt_q == '0)   state_d = ST_ARB;
            default:     state_d = ST_ARB;
        endcase
    end

    // Output logic: handshakes now, pin values for the next cycle
    always_comb begin
        bank_cmd_ready    = grant_onehot;
        refresh_cmd_ready = refresh_take;
        pins_d            = PINS_NOP;
        ba_d              = '0;
        addr_d            = '0;
        if (refresh_take) begin
            pins_d = PINS_REF;
        end else if (grant_any && (grant_pins != PINS_NOP)) begin
            pins_d = grant_pins;
            ba_d   = grant_idx;
            addr_d = bank_addr[grant_idx];
        end
    end

    // Pin registers, priority pointer and spacing/blackout counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pins_q    <= PINS_NOP;
            ba_q      <= '0;
            addr_q    <= '0;
            prio_q    <= '0;
            rrd_cnt_q <= '0;
            ccd_cnt_q <= '0;
            rfc_cnt_q <= '0;
        end else begin
            pins_q <= pins_d;
            ba_q   <= ba_d;
            addr_q <= addr_d;
            if (grant_any) begin
                prio_q <= grant_idx + BA_W'(1);
            end
            if (grant_any && (grant_type == CMD_ACT)) begin
                rrd_cnt_q <= RRD_W'(T_RRD - 1);
            end else if (rrd_cnt_q != '0) begin
                rrd_cnt_q <= rrd_cnt_q - RRD_W'(1);
            end
            if (grant_any && is_col_cmd(grant_type)) begin
                ccd_cnt_q <= CCD_W'(T_CCD - 1);
            end else if (ccd_cnt_q != '0) begin
                ccd_cnt_q <= ccd_cnt_q - CCD_W'(1);
            end
            if (refresh_take) begin
                rfc_cnt_q <= RFC_W'(T_RFC - 1);
            end else if ((state_q == ST_RFC_WAIT) && (rfc_cnt_q != '0)) begin
                rfc_cnt_q <= rfc_cnt_q - RFC_W'(1);
            end
        end
    end

    assign next_prio_bank = prio_q;
    assign ddr3_cs_n      = pins_q.cs_n;
    assign ddr3_ras_n     = pins_q.ras_n;
    assign ddr3_cas_n     = pins_q.cas_n;
    assign ddr3_we_n      = pins_q.we_n;
    assign ddr3_ba        = ba_q;
    assign ddr3_addr      = addr_q;

endmodule

// File: tb/tb_ddr3_cmd_arb.sv
// Self-checking bench for ddr3_cmd_arb: table of per-cycle vectors applied to
// an instance with T_RRD=4, T_CCD=4, T_RFC=10, plus a back-to-back READ
// burst on a second instance with T_CCD=1.
module tb_ddr3_cmd_arb;
    import ddr3_pkg::*;

    localparam logic [3:0] P_NOP = 4'b1111;
    localparam logic [3:0] P_ACT = 4'b0011;
    localparam logic [3:0] P_RD  = 4'b0101;
    localparam logic [3:0] P_WR  = 4'b0100;
    localparam logic [3:0] P_PRE = 4'b0010;
    localparam logic [3:0] P_REF = 4'b0001;

    // typ: one character per bank, bank 0 leftmost (A/R/W/P/N, X=undefined)
    typedef struct packed {
        logic        rstn;
        logic [7:0]  valid;
        logic [63:0] typ;
        logic        refresh;
        logic [7:0]  rdy;
        logic        rref;
        logic [3:0]  pins;
        logic [2:0]  ba;
        logic [2:0]  prio;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [7:0]            valid;
    ddr3_cmd_t [7:0]       typ;
    logic [7:0][13:0]      addr;
    logic                  refresh;

    logic [7:0]  rdy_a, rdy_b;
    logic [2:0]  prio_a, prio_b, ba_a, ba_b;
    logic        rref_a, rref_b;
    logic        cs_a, ras_a, cas_a, we_a, cs_b, ras_b, cas_b, we_b;
    logic [13:0] addr_a, addr_b;

    ddr3_cmd_arb #(.NUM_BANKS(8), .ADDR_W(14), .T_RRD(4), .T_CCD(4), .T_RFC(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .bank_cmd_valid(valid), .bank_cmd_type(typ),
        .bank_addr(addr), .bank_cmd_ready(rdy_a), .next_prio_bank(prio_a),
        .refresh_cmd_valid(refresh), .refresh_cmd_ready(rref_a),
        .ddr3_cs_n(cs_a), .ddr3_ras_n(ras_a), .ddr3_cas_n(cas_a), .ddr3_we_n(we_a),
        .ddr3_ba(ba_a), .ddr3_addr(addr_a)
    );

    ddr3_cmd_arb #(.NUM_BANKS(8), .ADDR_W(14), .T_RRD(4), .T_CCD(1), .T_RFC(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .bank_cmd_valid(valid), .bank_cmd_type(typ),
        .bank_addr(addr), .bank_cmd_ready(rdy_b), .next_prio_bank(prio_b),
        .refresh_cmd_valid(refresh), .refresh_cmd_ready(rref_b),
        .ddr3_cs_n(cs_b), .ddr3_ras_n(ras_b), .ddr3_cas_n(cas_b), .ddr3_we_n(we_b),
        .ddr3_ba(ba_b), .ddr3_addr(addr_b)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   row    = 0;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, got, want);
    endtask

    function automatic ddr3_cmd_t char2cmd(input logic [7:0] c);
        case (c)
            "A":     return CMD_ACT;
            "R":     return CMD_RD;
            "W":     return CMD_WR;
            "P":     return CMD_PRE;
            "X":     return ddr3_cmd_t'(3'd7);
            default: return CMD_NOP;
        endcase
    endfunction

    function automatic vec_t mk(input logic rstn, input logic [7:0] v, input logic [63:0] t,
                                input logic rf, input logic [7:0] rdy, input logic rref,
                                input logic [3:0] pins, input int ba, input int prio);
        return '{rstn, v, t, rf, rdy, rref, pins, 3'(ba), 3'(prio)};
    endfunction

    function automatic vec_t rst_row();
        return mk(1'b0, 8'h00, "........", 1'b0, 8'h00, 1'b0, P_NOP, 0, 0);
    endfunction

    // Drive one cycle on dut_a: handshakes before the edge, pins/pointer after.
    task automatic apply_row(input vec_t v);
        logic [13:0] exp_addr;
        rst_n   = v.rstn;
        valid   = v.valid;
        refresh = v.refresh;
        for (int b = 0; b < 8; b++) typ[b] = char2cmd(v.typ[8*(7-b) +: 8]);
        #1;
        chk("bank_ready", 32'(rdy_a), 32'(v.rdy));
        chk("refresh_ready", 32'(rref_a), 32'(v.rref));
        @(posedge clk);
        @(negedge clk);
        exp_addr = (v.pins == P_NOP || v.pins == P_REF) ? 14'h0 : addr[v.ba];
        chk("phy_cmd", 32'({cs_a, ras_a, cas_a, we_a, ba_a, addr_a}),
            32'({v.pins, v.ba, exp_addr}));
        chk("prio", 32'(prio_a), 32'(v.prio));
        row++;
    endtask

    initial begin
        rst_n   = 1'b0;
        valid   = '0;
        refresh = 1'b0;
        for (int b = 0; b < 8; b++) begin
            typ[b]  = CMD_NOP;
            addr[b] = 14'(14'h1000 + b * 37 + 5);
        end

        // Reset: readys held low even with every request and refresh pending
        vq.push_back(mk(1'b0, 8'hFF, "RRRRRRRR", 1'b1, 8'h00, 1'b0, P_NOP, 0, 0));
        // Basic round-robin with tRRD / tCCD skipping
        vq.push_back(mk(1'b1, 8'h00, "........", 1'b0, 8'h00, 1'b0, P_NOP, 0, 0));
        vq.push_back(mk(1'b1, 8'hFF, "AAAAAAAA", 1'b0, 8'h01, 1'b0, P_ACT, 0, 1));
        vq.push_back(mk(1'b1, 8'hFF, "AAAAAAAA", 1'b0, 8'h00, 1'b0, P_NOP, 0, 1));
        vq.push_back(mk(1'b1, 8'h08, "...P....", 1'b0, 8'h08, 1'b0, P_PRE, 3, 4));
        vq.push_back(mk(1'b1, 8'hFF, "AAAAAAAA", 1'b0, 8'h00, 1'b0, P_NOP, 0, 4));
        vq.push_back(mk(1'b1, 8'hFF, "AAAAAAAA", 1'b0, 8'h10, 1'b0, P_ACT, 4, 5));
        vq.push_back(mk(1'b1, 8'h04, "..R.....", 1'b0, 8'h04, 1'b0, P_RD,  2, 3));
        vq.push_back(mk(1'b1, 8'h42, ".R....W.", 1'b0, 8'h00, 1'b0, P_NOP, 0, 3));
        vq.push_back(mk(1'b1, 8'h0A, ".P.W....", 1'b0, 8'h02, 1'b0, P_PRE, 1, 2));
        vq.push_back(mk(1'b1, 8'h28, "...R.A..", 1'b0, 8'h20, 1'b0, P_ACT, 5, 6));
        vq.push_back(mk(1'b1, 8'h88, "...R...A", 1'b0, 8'h08, 1'b0, P_RD,  3, 4));
        vq.push_back(mk(1'b1, 8'h11, "X...N...", 1'b0, 8'h10, 1'b0, P_NOP, 0, 5));
        vq.push_back(mk(1'b1, 8'h01, "X.......", 1'b0, 8'h01, 1'b0, P_NOP, 0, 1));
        // tRRD: bank 2 ACT at cycle 0, bank 5 ACT waits until cycle 4
        vq.push_back(rst_row());
        vq.push_back(mk(1'b1, 8'h04, "..A.....", 1'b0, 8'h04, 1'b0, P_ACT, 2, 3));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1'b1, 8'h20, ".....A..", 1'b0, 8'h00, 1'b0, P_NOP, 0, 3));
        vq.push_back(mk(1'b1, 8'h20, ".....A..", 1'b0, 8'h20, 1'b0, P_ACT, 5, 6));
        // tCCD: ACT overtakes a spacing-blocked READ
        vq.push_back(rst_row());
        vq.push_back(mk(1'b1, 8'h02, ".W......", 1'b0, 8'h02, 1'b0, P_WR,  1, 2));
        vq.push_back(mk(1'b1, 8'h18, "...RA...", 1'b0, 8'h10, 1'b0, P_ACT, 4, 5));
        vq.push_back(mk(1'b1, 8'h08, "...R....", 1'b0, 8'h00, 1'b0, P_NOP, 0, 5));
        vq.push_back(mk(1'b1, 8'h08, "...R....", 1'b0, 8'h00, 1'b0, P_NOP, 0, 5));
        vq.push_back(mk(1'b1, 8'h08, "...R....", 1'b0, 8'h08, 1'b0, P_RD,  3, 4));
        // Refresh beats bank 6, 10-cycle blackout, pointer kept
        vq.push_back(rst_row());
        vq.push_back(mk(1'b1, 8'h02, ".P......", 1'b0, 8'h02, 1'b0, P_PRE, 1, 2));
        vq.push_back(mk(1'b1, 8'h40, "......R.", 1'b1, 8'h00, 1'b1, P_REF, 0, 2));
        vq.push_back(mk(1'b1, 8'h40, "......R.", 1'b1, 8'h00, 1'b0, P_NOP, 0, 2));
        for (int i = 0; i < 9; i++)
            vq.push_back(mk(1'b1, 8'h40, "......R.", 1'b0, 8'h00, 1'b0, P_NOP, 0, 2));
        vq.push_back(mk(1'b1, 8'h40, "......R.", 1'b0, 8'h40, 1'b0, P_RD,  6, 7));
        // Reset during blackout abandons it
        vq.push_back(rst_row());
        vq.push_back(mk(1'b1, 8'h02, ".R......", 1'b0, 8'h02, 1'b0, P_RD,  1, 2));
        vq.push_back(mk(1'b1, 8'h01, "R.......", 1'b1, 8'h00, 1'b1, P_REF, 0, 2));
        vq.push_back(mk(1'b1, 8'h01, "R.......", 1'b0, 8'h00, 1'b0, P_NOP, 0, 2));
        vq.push_back(mk(1'b0, 8'h01, "R.......", 1'b0, 8'h00, 1'b0, P_NOP, 0, 0));
        vq.push_back(mk(1'b1, 8'h01, "R.......", 1'b0, 8'h01, 1'b0, P_RD,  0, 1));

        @(negedge clk);
        foreach (vq[i]) apply_row(vq[i]);

        // Back-to-back READs with T_CCD=1: one grant per cycle, 0..7
        apply_row(rst_row());
        for (int k = 0; k < 8; k++) begin
            rst_n   = 1'b1;
            valid   = 8'hFF;
            refresh = 1'b0;
            for (int b = 0; b < 8; b++) typ[b] = CMD_RD;
            #1;
            chk("burst_ready", 32'(rdy_b), 32'(8'h01 << k));
            chk("burst_refresh_ready", 32'(rref_b), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("burst_phy_cmd", 32'({cs_b, ras_b, cas_b, we_b, ba_b, addr_b}),
                32'({P_RD, 3'(k), addr[k]}));
            chk("burst_prio", 32'(prio_b), 32'((k + 1) % 8));
            row++;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
